// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates, aligns and sequences one byte/half/word access
// at a time against a single-cycle word memory, then returns the extended load result.
module load_store_unit #(
    parameter int DataWidth = 32,
    parameter int Address   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_valid,
    input  logic                 lsu_we,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [DataWidth-1:0] wdata,
    output logic                 lsu_busy,
    output logic                 lsu_done,
    output logic                 lsu_err,
    output logic [DataWidth-1:0] rdata,
    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [3:0]           mem_mask,
    output logic [Address-1:0]   mem_address,
    output logic [DataWidth-1:0] mem_data_in,
    input  logic [DataWidth-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   err_q, err_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             offset_q, offset_d;
    logic                   mem_we_re_q, mem_we_re_d;
    logic [3:0]             mem_mask_q, mem_mask_d;
    logic [Address-1:0]     mem_address_q, mem_address_d;
    logic [DataWidth-1:0]   mem_data_in_q, mem_data_in_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   lsu_busy_q, lsu_busy_d;
    logic                   lsu_done_q, lsu_done_d;
    logic                   lsu_err_q, lsu_err_d;
    logic                   mem_request_q, mem_request_d;
    logic                   unused_addr_s;

    // Address bits above the memory window are deliberately dropped so accesses wrap.
    assign unused_addr_s = ^addr[31:Address+2];

    function automatic logic access_rejected(input logic we, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic rej;
        case (f3)
            3'd0:    rej = 1'b0;
            3'd1:    rej = a[0];
            3'd2:    rej = (a != 2'b00);
            3'd4:    rej = we;
            3'd5:    rej = we | a[0];
            default: rej = 1'b1;
        endcase
        return rej;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'd0:    m = 4'b0001 << a;
            2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DataWidth-1:0] store_data(input logic [2:0] f3,
                                                        input logic [DataWidth-1:0] wd);
        logic [DataWidth-1:0] d;
        case (f3[1:0])
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DataWidth-1:0] load_extend(input logic [2:0] f3,
                                                         input logic [1:0] off,
                                                         input logic [DataWidth-1:0] word);
        logic [7:0]           b;
        logic [15:0]          h;
        logic [DataWidth-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Sequencing: accept/reject in IDLE, one memory strobe in ACCESS, capture in WAIT.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    if (access_rejected(lsu_we, funct3, addr[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        err_d         = 1'b0;
                        funct3_d      = funct3;
                        offset_d      = addr[1:0];
                        mem_we_re_d   = lsu_we;
                        mem_address_d = addr[Address+1:2];
                        if (lsu_we) begin
                            mem_mask_d    = store_mask(funct3, addr[1:0]);
                            mem_data_in_d = store_data(funct3, wdata);
                        end else begin
                            mem_mask_d    = 4'b1111;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (mem_we_re_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d = load_extend(funct3_q, offset_q, mem_data_out);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Status outputs are registered decodes of the state being entered.
    always_comb begin
        lsu_busy_d    = (state_d != IDLE);
        lsu_done_d    = (state_d == DONE);
        lsu_err_d     = (state_d == DONE) && err_d;
        mem_request_d = (state_d == ACCESS);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            err_q         <= 1'b0;
            funct3_q      <= '0;
            offset_q      <= '0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rdata_q       <= '0;
            lsu_busy_q    <= 1'b0;
            lsu_done_q    <= 1'b0;
            lsu_err_q     <= 1'b0;
            mem_request_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rdata_q       <= rdata_d;
            lsu_busy_q    <= lsu_busy_d;
            lsu_done_q    <= lsu_done_d;
            lsu_err_q     <= lsu_err_d;
            mem_request_q <= mem_request_d;
        end
    end

    assign lsu_busy    = lsu_busy_q;
    assign lsu_done    = lsu_done_q;
    assign lsu_err     = lsu_err_q;
    assign rdata       = rdata_q;
    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_mask    = mem_mask_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a latency/byte-lane reference model plus a
// behavioural word memory, compared against the DUT on every cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n, lsu_valid, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] rdata;
    logic        mem_request, mem_we_re;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'd0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DataWidth(32), .Address(8)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_we(lsu_we),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err), .rdata(rdata),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory driven by the DUT's strobes; read data appears the cycle after the request.
    always @(posedge clk) begin
        if (rst_n && mem_request) begin
            if (mem_we_re) begin
                for (int i = 0; i < 4; i++)
                    if (mem_mask[i]) mem[mem_address][8*i +: 8] <= mem_data_in[8*i +: 8];
            end else begin
                mem_data_out <= mem[mem_address];
            end
        end
    end

    // Reference model: each accepted command owns the unit for a fixed number of cycles.
    int          phase = 0;
    int          lat = 0;
    bit          t_err = 1'b0, t_store = 1'b0, started = 1'b0, din_known = 1'b1;
    logic [31:0] exp_rdata = 32'd0, exp_din = 32'd0, pend_rdata = 32'd0;
    logic [7:0]  exp_addr = 8'd0;
    logic [3:0]  exp_mask = 4'd0;
    logic        exp_we = 1'b0;

    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit rejected(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        return (int'(a[1:0]) % acc_bytes(f3)) != 0;
    endfunction

    always @(posedge clk) begin
        int          nb, off, lanes;
        logic [7:0]  idx;
        logic [31:0] val;
        if (!rst_n) begin
            phase = 0; lat = 0; t_err = 1'b0; t_store = 1'b0;
            exp_rdata = 32'd0; exp_addr = 8'd0; exp_mask = 4'd0; exp_we = 1'b0;
            exp_din = 32'd0; din_known = 1'b1; started = 1'b1;
        end else if (phase == 0) begin
            if (lsu_valid) begin
                t_err   = rejected(lsu_we, funct3, addr);
                t_store = lsu_we;
                lat     = t_err ? 1 : (lsu_we ? 2 : 3);
                phase   = 1;
                if (!t_err) begin
                    nb = acc_bytes(funct3);
                    off = int'(addr[1:0]);
                    idx = addr[9:2];
                    exp_addr = idx;
                    exp_we = lsu_we;
                    if (lsu_we) begin
                        lanes = ((1 << nb) - 1) << off;
                        exp_mask = lanes[3:0];
                        if (nb == 1)      exp_din = wdata[7:0] * 32'h0101_0101;
                        else if (nb == 2) exp_din = wdata[15:0] * 32'h0001_0001;
                        else              exp_din = wdata;
                        for (int i = 0; i < 4; i++)
                            if (exp_mask[i]) ref_mem[idx][8*i +: 8] = exp_din[8*i +: 8];
                        din_known = 1'b1;
                    end else begin
                        exp_mask = 4'hF;
                        din_known = 1'b0;
                        val = (ref_mem[idx] >> (8 * off)) & ((32'd1 << (8 * nb)) - 32'd1);
                        if (!funct3[2] && nb < 4 && val[8*nb-1])
                            val = val - (32'd1 << (8 * nb));
                        pend_rdata = val;
                    end
                end
            end
        end else if (phase == lat) begin
            phase = 0;
        end else begin
            phase = phase + 1;
        end
        if (rst_n && phase == 3 && !t_store && !t_err) exp_rdata = pend_rdata;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", {31'd0, lsu_busy}, {31'd0, phase != 0});
            chk("done", {31'd0, lsu_done}, {31'd0, phase != 0 && phase == lat});
            chk("err", {31'd0, lsu_err}, {31'd0, phase != 0 && phase == lat && t_err});
            chk("mem_request", {31'd0, mem_request}, {31'd0, phase == 1 && !t_err});
            chk("rdata", rdata, exp_rdata);
            chk("mem_we_re", {31'd0, mem_we_re}, {31'd0, exp_we});
            chk("mem_mask", {28'd0, mem_mask}, {28'd0, exp_mask});
            chk("mem_address", {24'd0, mem_address}, {24'd0, exp_addr});
            if (din_known) chk("mem_data_in", mem_data_in, exp_din);
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        lsu_valid = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        lsu_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 8; i++) begin
            if (!lsu_busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, lsu_busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h80FF_7F01;
        ref_mem[0] = 32'h80FF_7F01;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mask", {28'd0, mem_mask}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 3'd0, 32'h0000_0006, 32'h0000_00AB);
        chk("sb_req", {31'd0, mem_request}, 32'd1);
        chk("sb_addr", {24'd0, mem_address}, 32'd1);
        chk("sb_mask", {28'd0, mem_mask}, 32'h4);
        chk("sb_din", mem_data_in, 32'hABAB_ABAB);
        chk("sb_we", {31'd0, mem_we_re}, 32'd1);
        @(negedge clk);
        chk("sb_done_c2", {31'd0, lsu_done}, 32'd1);
        @(negedge clk);

        issue(1'b0, 3'd0, 32'h0000_0003, 32'd0);
        chk("lb_mask", {28'd0, mem_mask}, 32'hF);
        @(negedge clk);
        chk("lb_done_c2", {31'd0, lsu_done}, 32'd0);
        @(negedge clk);
        chk("lb_done_c3", {31'd0, lsu_done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        @(negedge clk);
        issue(1'b0, 3'd5, 32'h0000_0002, 32'd0);
        repeat (2) @(negedge clk);
        chk("lhu_rdata", rdata, 32'h0000_80FF);
        @(negedge clk);

        issue(1'b0, 3'd2, 32'h0000_0002, 32'd0);
        chk("mis_done", {31'd0, lsu_done}, 32'd1);
        chk("mis_err", {31'd0, lsu_err}, 32'd1);
        chk("mis_req", {31'd0, mem_request}, 32'd0);
        chk("mis_rdata_hold", rdata, 32'h0000_80FF);
        @(negedge clk);

        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'd2; addr = 32'h0000_0004;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b2b_busy", {31'd0, lsu_busy}, 32'd1);
        end
        @(negedge clk);
        chk("b2b_gap", {31'd0, lsu_busy}, 32'd0);
        @(negedge clk);
        chk("b2b_second", {31'd0, mem_request}, 32'd1);
        lsu_valid = 1'b0;
        wait_idle();

        issue(1'b0, 3'd2, 32'h0000_0000, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rw_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rw_rdata", rdata, 32'd0);
        @(negedge clk);
        chk("rw_no_done", {31'd0, lsu_done}, 32'd0);

        issue(1'b1, 3'd2, 32'h0000_0400, 32'h1234_5678);
        chk("wrap_addr", {24'd0, mem_address}, 32'd0);
        chk("wrap_mask", {28'd0, mem_mask}, 32'hF);
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_we    = 1'($urandom_range(0, 1));
            funct3    = 3'($urandom_range(0, 7));
            addr      = $urandom;
            if ($urandom_range(0, 1) == 1) addr[9:4] = 6'd0;
            wdata     = $urandom;
            @(negedge clk);
        end
        rst_n = 1'b1;
        lsu_valid = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
